// File: rtl/writeback_arbiter.sv
// Write-back stage: fixed-priority collection of load/mul/alu results into a small FIFO
// that drains one register-file write per cycle, plus a per-register pending scoreboard.
module writeback_arbiter #(
    parameter int register_width = 32,
    parameter int fifo_depth     = 4
) (
    input  logic                          clk,
    input  logic                          resetn,

    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [4:0]                    load_addr,
    input  logic [register_width-1:0]     load_data,

    input  logic                          mul_valid,
    output logic                          mul_ready,
    input  logic [4:0]                    mul_addr,
    input  logic [register_width-1:0]     mul_data,

    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_addr,
    input  logic [register_width-1:0]     alu_data,

    input  logic                          issue_en,
    input  logic [4:0]                    issue_rd,
    input  logic [4:0]                    rs1_addr,
    input  logic [4:0]                    rs2_addr,
    input  logic [4:0]                    rs3_addr,
    output logic                          hazard,

    output logic                          register_to_write_en,
    output logic [4:0]                    register_to_write_addr,
    output logic [register_width-1:0]     register_to_write_data,
    output logic [$clog2(fifo_depth):0]   fifo_count
);

    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);

    logic [4:0]                fifo_addr [fifo_depth];
    logic [register_width-1:0] fifo_data [fifo_depth];
    logic [ptr_w-1:0]          wr_ptr;
    logic [ptr_w-1:0]          rd_ptr;
    logic [cnt_w-1:0]          count;
    logic [31:0]               pending;
    logic [31:0]               pending_next;
    logic                      pop;
    logic                      push;
    logic                      space;
    logic [4:0]                sel_addr;
    logic [register_width-1:0] sel_data;

    // The register file never back-pressures, so any queued entry drains this cycle.
    assign pop   = (count != '0);
    assign space = (count != depth_c) || pop;

    assign load_ready = resetn && load_valid && space;
    assign mul_ready  = resetn && mul_valid && !load_valid && space;
    assign alu_ready  = resetn && alu_valid && !load_valid && !mul_valid && space;

    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (mul_valid) begin
            sel_addr = mul_addr;
            sel_data = mul_data;
        end
        if (load_valid) begin
            sel_addr = load_addr;
            sel_data = load_data;
        end
    end

    // Results for x0 complete the handshake but are dropped here.
    assign push = (load_ready || mul_ready || alu_ready) && (sel_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= sel_addr;
            fifo_data[wr_ptr] <= sel_data;
        end
    end

    always_comb begin
        pending_next = pending;
        if (register_to_write_en) begin
            pending_next[register_to_write_addr] = 1'b0;
        end
        if (issue_en) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            count                  <= '0;
            register_to_write_en   <= 1'b0;
            register_to_write_addr <= '0;
            register_to_write_data <= '0;
            pending                <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr                 <= rd_ptr + ptr_w'(1);
                register_to_write_addr <= fifo_addr[rd_ptr];
                register_to_write_data <= fifo_data[rd_ptr];
            end
            register_to_write_en <= pop;
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            pending <= pending_next;
        end
    end

    assign hazard     = pending[rs1_addr] | pending[rs2_addr] | pending[rs3_addr];
    assign fifo_count = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          resetn     = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [4:0]    load_addr  = '0;
    logic [W-1:0]  load_data  = '0;
    logic          mul_valid  = 1'b0;
    logic          mul_ready;
    logic [4:0]    mul_addr   = '0;
    logic [W-1:0]  mul_data   = '0;
    logic          alu_valid  = 1'b0;
    logic          alu_ready;
    logic [4:0]    alu_addr   = '0;
    logic [W-1:0]  alu_data   = '0;
    logic          issue_en   = 1'b0;
    logic [4:0]    issue_rd   = '0;
    logic [4:0]    rs1_addr   = '0;
    logic [4:0]    rs2_addr   = '0;
    logic [4:0]    rs3_addr   = '0;
    logic          hazard;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(.register_width(W), .fifo_depth(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_addr(mul_addr), .mul_data(mul_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr), .hazard(hazard),
        .register_to_write_en(wr_en), .register_to_write_addr(wr_addr),
        .register_to_write_data(wr_data), .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of accepted results, the value on the write port,
    // and a pending bit per register.
    bit [36:0] q[$];
    bit        m_en;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit [31:0] m_pend;
    bit        acc_l, acc_m, acc_a;

    function automatic void exp_ready(output bit rl, output bit rm, output bit ra);
        bit space;
        space = (q.size() < DEPTH) || (q.size() != 0);
        rl = resetn && load_valid && space;
        rm = resetn && mul_valid && !load_valid && space;
        ra = resetn && alu_valid && !load_valid && !mul_valid && space;
    endfunction

    always @(posedge clk) begin
        bit rl, rm, ra;
        if (resetn) begin
            exp_ready(rl, rm, ra);
            if (m_en) m_pend[m_addr] = 1'b0;
            if (issue_en && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
            if (q.size() != 0) begin
                {m_addr, m_data} = q.pop_front();
                m_en = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            if (rl && load_addr != 5'd0) q.push_back({load_addr, load_data});
            if (rm && mul_addr  != 5'd0) q.push_back({mul_addr,  mul_data});
            if (ra && alu_addr  != 5'd0) q.push_back({alu_addr,  alu_data});
            acc_l = rl;
            acc_m = rm;
            acc_a = ra;
        end
    end

    always @(negedge resetn) begin
        q.delete();
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_pend = '0;
        acc_l  = 1'b0;
        acc_m  = 1'b0;
        acc_a  = 1'b0;
    end

    always @(negedge clk) begin
        bit rl, rm, ra;
        exp_ready(rl, rm, ra);
        chk("m_load_ready", load_ready, rl);
        chk("m_mul_ready",  mul_ready,  rm);
        chk("m_alu_ready",  alu_ready,  ra);
        chk("m_wr_en",      wr_en,      m_en);
        chk("m_wr_addr",    wr_addr,    m_addr);
        chk("m_wr_data",    wr_data,    m_data);
        chk("m_fifo_count", fifo_count, q.size());
        chk("m_count_bound", fifo_count <= DEPTH, 1);
        chk("m_hazard", hazard, m_pend[rs1_addr] | m_pend[rs2_addr] | m_pend[rs3_addr]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        // Reset: everything zero, ready held low even with a valid source.
        #2 resetn = 1'b0;
        load_valid = 1'b1;
        load_addr  = 5'd4;
        #1;
        chk("rst_load_ready", load_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_hazard", hazard, 0);
        tick();
        tick();
        load_valid = 1'b0;
        resetn = 1'b1;
        tick();

        // Single write.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        neg();
        chk("single_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        neg();
        chk("single_count_1", fifo_count, 1);
        chk("single_en_0", wr_en, 0);
        tick();
        neg();
        chk("single_en", wr_en, 1);
        chk("single_addr", wr_addr, 5);
        chk("single_data", wr_data, 32'h1234);
        chk("single_count_0", fifo_count, 0);
        tick();
        neg();
        chk("single_en_after", wr_en, 0);
        chk("single_addr_hold", wr_addr, 5);

        // Priority: all three together.
        tick();
        load_valid = 1'b1; load_addr = 5'd1; load_data = 32'h11;
        mul_valid  = 1'b1; mul_addr  = 5'd2; mul_data  = 32'h22;
        alu_valid  = 1'b1; alu_addr  = 5'd3; alu_data  = 32'h33;
        neg();
        chk("prio_load_ready", load_ready, 1);
        chk("prio_mul_wait", mul_ready, 0);
        chk("prio_alu_wait", alu_ready, 0);
        tick();
        load_valid = 1'b0;
        neg();
        chk("prio_mul_ready", mul_ready, 1);
        chk("prio_alu_wait2", alu_ready, 0);
        tick();
        mul_valid = 1'b0;
        neg();
        chk("prio_alu_ready", alu_ready, 1);
        chk("prio_wr1", {wr_en, wr_addr}, {1'b1, 5'd1});
        tick();
        alu_valid = 1'b0;
        neg();
        chk("prio_wr2", {wr_en, wr_addr}, {1'b1, 5'd2});
        tick();
        neg();
        chk("prio_wr3", {wr_en, wr_addr, wr_data}, {1'b1, 5'd3, 32'h33});
        tick();
        neg();
        chk("prio_idle", wr_en, 0);

        // Result for x0 is swallowed.
        tick();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
        neg();
        chk("x0_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("x0_en", wr_en, 0);
            chk("x0_count", fifo_count, 0);
            tick();
        end

        // Hazard tracking on register 7.
        issue_en = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
        neg();
        chk("haz_before_issue", hazard, 0);
        tick();
        issue_en = 1'b0;
        neg();
        chk("haz_after_issue", hazard, 1);
        tick();
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA5;
        tick();
        alu_valid = 1'b0;
        neg();
        chk("haz_queued", hazard, 1);
        tick();
        issue_en = 1'b1; issue_rd = 5'd7;
        neg();
        chk("haz_presented_en", {wr_en, wr_addr}, {1'b1, 5'd7});
        chk("haz_presented", hazard, 1);
        tick();
        issue_en = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h5A;
        neg();
        chk("haz_set_wins", hazard, 1);
        tick();
        alu_valid = 1'b0;
        tick();
        neg();
        chk("haz_second_presented", hazard, 1);
        tick();
        neg();
        chk("haz_cleared", hazard, 0);
        issue_en = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        issue_en = 1'b0;
        neg();
        chk("haz_x0", hazard, 0);
        tick();

        // Randomized traffic with held-while-stalled sources.
        for (int c = 0; c < 400; c++) begin
            if (!load_valid || acc_l) begin
                load_valid = ($urandom_range(0, 2) == 0);
                load_addr  = 5'($urandom_range(0, 31));
                load_data  = $urandom;
            end
            if (!mul_valid || acc_m) begin
                mul_valid = ($urandom_range(0, 1) == 0);
                mul_addr  = 5'($urandom_range(0, 31));
                mul_data  = $urandom;
            end
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 1) == 0);
                alu_addr  = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            issue_en = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 31));
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            rs3_addr = 5'($urandom_range(0, 31));
            tick();
        end
        load_valid = 1'b0; mul_valid = 1'b0; alu_valid = 1'b0; issue_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Reset in the middle of a stream.
        issue_en = 1'b1; issue_rd = 5'd10; tick();
        issue_rd = 5'd11; tick();
        issue_rd = 5'd12; tick();
        issue_en = 1'b0;
        rs1_addr = 5'd10; rs2_addr = 5'd11; rs3_addr = 5'd12;
        load_valid = 1'b1; load_addr = 5'd10; load_data = 32'hAAAA;
        mul_valid  = 1'b1; mul_addr  = 5'd11; mul_data  = 32'hBBBB;
        alu_valid  = 1'b1; alu_addr  = 5'd12; alu_data  = 32'hCCCC;
        tick();
        load_valid = 1'b0;
        tick();
        mul_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_en", wr_en, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_hazard", hazard, 0);
        chk("mid_rst_alu_ready", alu_ready, 0);
        alu_valid = 1'b0;
        #3 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("post_rst_en", wr_en, 0);
            chk("post_rst_hazard", hazard, 0);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
